alu_op_sequencer: RTL and testbench

- Multi-cycle successor to the ALU's combinational op decoder. Accepts an op on a start/ready handshake and latches it.
- Asserts exactly one functional-unit enable for a parameterised number of cycles per op, then pulses done.
- Sits between the ALU front end (operand/op capture) and the adder/subtractor/multiplier/divider units.
- Adds the parts the decoder lacks: busy tracking, per-op latency, and a divide-by-zero short-circuit.

---
 rtl/alu_op_sequencer.sv | 122 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU op sequencer: accepts an op, runs exactly one unit enable for its latency, then pulses done.
// Optional abort input enabled by defining ALU_SEQ_ABORT_EN.
module alu_op_sequencer #(
   parameter int ADD_LAT = 1,
   parameter int SUB_LAT = 1,
   parameter int MUL_LAT = 8,
   parameter int DIV_LAT = 8,
   parameter int CNT_W   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [1:0] op,
   input  logic       div_zero,
`ifdef ALU_SEQ_ABORT_EN
   input  logic       abort,
`endif
   output logic       ready,
   output logic       busy,
   output logic       add_en,
   output logic       sub_en,
   output logic       mul_en,
   output logic       div_en,
   output logic       done,
   output logic       err,
   output logic [1:0] op_q
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] ADD_CNT = CNT_W'(ADD_LAT - 1);
   localparam logic [CNT_W-1:0] SUB_CNT = CNT_W'(SUB_LAT - 1);
   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       op_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] latLoad;
   logic             abortHit;

`ifdef ALU_SEQ_ABORT_EN
   assign abortHit = abort;
`else
   assign abortHit = 1'b0;
`endif

   always_comb begin
      latLoad = ADD_CNT;
      case (op)
         2'b00:   latLoad = ADD_CNT;
         2'b01:   latLoad = SUB_CNT;
         2'b10:   latLoad = MUL_CNT;
         default: latLoad = DIV_CNT;
      endcase
   end

   // Divide-by-zero skips EXEC entirely so the divider is never enabled.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d  = op;
               cnt_d = latLoad;
               if (op == 2'b11 && div_zero) begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d = EXEC;
                  err_d   = 1'b0;
               end
            end
         end
         EXEC: begin
            if (abortHit) begin
               state_d = DONE;
               err_d   = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= 2'b00;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         err_q   <= err_d;
      end
   end

   // Every output is a decode of registered state, so no input reaches an output combinationally.
   assign ready  = (state_q == IDLE);
   assign busy   = (state_q == EXEC) || (state_q == DONE);
   assign done   = (state_q == DONE);
   assign err    = err_q;
   assign add_en = (state_q == EXEC) && (op_q == 2'b00);
   assign sub_en = (state_q == EXEC) && (op_q == 2'b01);
   assign mul_en = (state_q == EXEC) && (op_q == 2'b10);
   assign div_en = (state_q == EXEC) && (op_q == 2'b11);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed, table-driven bench for alu_op_sequencer with default latencies (1/1/8/8).
// Covers the abort path when ALU_SEQ_ABORT_EN is defined.
module tb_alu_op_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [1:0] op;
   logic       div_zero;
   logic       ready, busy, add_en, sub_en, mul_en, div_en, done, err;
   logic [1:0] op_q;
`ifdef ALU_SEQ_ABORT_EN
   logic       abort;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [1:0] op;
      logic       dz;
      int         lat;
      logic       err;
   } vec_t;

   alu_op_sequencer dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .div_zero (div_zero),
`ifdef ALU_SEQ_ABORT_EN
      .abort    (abort),
`endif
      .ready    (ready),
      .busy     (busy),
      .add_en   (add_en),
      .sub_en   (sub_en),
      .mul_en   (mul_en),
      .div_en   (div_en),
      .done     (done),
      .err      (err),
      .op_q     (op_q)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] enVec();
      return {div_en, mul_en, sub_en, add_en};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one edge and sample 1ns later; the one-hot rule is checked every cycle.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
      checkOutput("enable one-hot", 32'($onehot0(enVec())), 32'd1);
   endtask

   task automatic runOp(input vec_t v);
      logic [3:0] expEn;
      int         enCount;
      int         doneCycle;
      expEn     = 4'b0001 << v.op;
      enCount   = 0;
      doneCycle = 0;
      checkOutput("ready before start", 32'(ready), 32'd1);
      start    = 1'b1;
      op       = v.op;
      div_zero = v.dz;
      applyStimulus();
      op       = ~v.op;
      div_zero = ~v.dz;
      for (int k = 1; k <= 40; k++) begin
         if (done) begin
            doneCycle = k;
            break;
         end
         if (enVec() != 4'b0000) begin
            checkOutput("enable select", 32'(enVec()), 32'(expEn));
            enCount++;
         end
         start = k[0];
         applyStimulus();
      end
      start = 1'b0;
      if (doneCycle == 0) begin
         checkOutput("done timeout", 32'd0, 32'd1);
      end else begin
         checkOutput("enable cycles", 32'(enCount), 32'(v.lat));
         checkOutput("done latency", 32'(doneCycle), 32'(v.lat + 1));
         checkOutput("err at done", 32'(err), 32'(v.err));
         checkOutput("op_q", 32'(op_q), 32'(v.op));
         checkOutput("busy at done", 32'(busy), 32'd1);
         checkOutput("enables at done", 32'(enVec()), 32'd0);
         applyStimulus();
         checkOutput("ready after done", 32'(ready), 32'd1);
         checkOutput("done one cycle", 32'(done), 32'd0);
         checkOutput("err holds", 32'(err), 32'(v.err));
      end
   endtask

   vec_t vecs[8];

   initial begin
      vecs[0] = '{op: 2'b00, dz: 1'b0, lat: 1, err: 1'b0};
      vecs[1] = '{op: 2'b01, dz: 1'b0, lat: 1, err: 1'b0};
      vecs[2] = '{op: 2'b10, dz: 1'b0, lat: 8, err: 1'b0};
      vecs[3] = '{op: 2'b11, dz: 1'b1, lat: 0, err: 1'b1};
      vecs[4] = '{op: 2'b00, dz: 1'b0, lat: 1, err: 1'b0};
      vecs[5] = '{op: 2'b11, dz: 1'b0, lat: 8, err: 1'b0};
      vecs[6] = '{op: 2'b10, dz: 1'b1, lat: 8, err: 1'b0};
      vecs[7] = '{op: 2'b01, dz: 1'b0, lat: 1, err: 1'b0};

      rst_n    = 1'b0;
      start    = 1'b0;
      op       = 2'b00;
      div_zero = 1'b0;
`ifdef ALU_SEQ_ABORT_EN
      abort    = 1'b0;
`endif
      applyStimulus();
      applyStimulus();
      rst_n = 1'b1;
      checkOutput("reset ready", 32'(ready), 32'd1);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset err", 32'(err), 32'd0);
      checkOutput("reset enables", 32'(enVec()), 32'd0);

      for (int i = 0; i < 8; i++) runOp(vecs[i]);

      // Reset in the middle of a multiply aborts it with no done pulse.
      start = 1'b1;
      op    = 2'b10;
      applyStimulus();
      start = 1'b0;
      applyStimulus();
      applyStimulus();
      checkOutput("mid-mul mul_en", 32'(mul_en), 32'd1);
      rst_n = 1'b0;
      applyStimulus();
      checkOutput("in-reset done", 32'(done), 32'd0);
      applyStimulus();
      rst_n = 1'b1;
      checkOutput("mid-reset ready", 32'(ready), 32'd1);
      checkOutput("mid-reset busy", 32'(busy), 32'd0);
      checkOutput("mid-reset enables", 32'(enVec()), 32'd0);
      checkOutput("mid-reset done", 32'(done), 32'd0);
      checkOutput("mid-reset op_q", 32'(op_q), 32'd0);
      applyStimulus();
      checkOutput("post-reset done", 32'(done), 32'd0);
      checkOutput("post-reset idle", 32'(ready), 32'd1);

      // Back-to-back subtracts with start held: period of 3 cycles.
      start = 1'b1;
      op    = 2'b01;
      applyStimulus();
      checkOutput("b2b c1 sub_en", 32'(sub_en), 32'd1);
      applyStimulus();
      checkOutput("b2b c2 done", 32'(done), 32'd1);
      applyStimulus();
      checkOutput("b2b c3 ready", 32'(ready), 32'd1);
      applyStimulus();
      start = 1'b0;
      checkOutput("b2b c4 sub_en", 32'(sub_en), 32'd1);
      applyStimulus();
      checkOutput("b2b c5 done", 32'(done), 32'd1);
      applyStimulus();
      checkOutput("b2b c6 ready", 32'(ready), 32'd1);

`ifdef ALU_SEQ_ABORT_EN
      // Abort on the third EXEC cycle of a divide.
      start = 1'b1;
      op    = 2'b11;
      div_zero = 1'b0;
      applyStimulus();
      start = 1'b0;
      applyStimulus();
      applyStimulus();
      checkOutput("abort c3 div_en", 32'(div_en), 32'd1);
      abort = 1'b1;
      applyStimulus();
      abort = 1'b0;
      checkOutput("abort div_en drop", 32'(div_en), 32'd0);
      checkOutput("abort done", 32'(done), 32'd1);
      checkOutput("abort err", 32'(err), 32'd1);
      abort = 1'b1;
      applyStimulus();
      checkOutput("abort ready", 32'(ready), 32'd1);
      applyStimulus();
      abort = 1'b0;
      checkOutput("abort idle ignored", 32'(ready), 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
